// File: rtl/vga_pkg.sv
// Shared types for the VGA mode sequencer: video mode indices and controller states.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_1280X720 = 2'd2
    } mode_t;

    localparam int NUM_MODES_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RECONF,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_UNBLANK,
        ST_FAULT
    } ctrl_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module cdc_sync_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_bit <= RST_VAL;
        end else begin
            meta_reg <= async_bit;
            sync_bit <= meta_reg;
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Runtime VGA mode sequencer: debounces the mode switches, reprograms the pixel PLL on a
// frame boundary while holding the timing generator, and recovers from lock loss/timeouts.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_MODES       = NUM_MODES_DEFAULT,
    parameter int DEFAULT_MODE    = 0,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FRAME_TIMEOUT   = 2_500_000,
    parameter int LOCK_TIMEOUT    = 5_000_000,
    parameter int SETTLE_CYCLES   = 1024
) (
    input  logic       SYS_CLK,
    input  logic       RESET_N,
    input  logic [1:0] mode_req_i,
    input  logic       frame_tgl_i,
    input  logic       pll_locked_i,
    input  logic       pll_cfg_done_i,
    output logic       pll_cfg_req_o,
    output logic [1:0] pll_cfg_mode_o,
    output logic       tg_rst_o,
    output logic       tg_blank_o,
    output logic [1:0] active_mode_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int FL_MAX  = (FRAME_TIMEOUT > LOCK_TIMEOUT) ? FRAME_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_MAX = (FL_MAX > SETTLE_CYCLES) ? FL_MAX : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam mode_t            DEF_MODE    = mode_t'(2'(DEFAULT_MODE));

    logic             lock_sync;
    logic             frame_sync;
    logic             frame_dly_reg;
    logic             frame_evt_reg;
    logic [1:0]       cand_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic [CNT_W-1:0] cnt_reg;
    ctrl_state_t      state_reg;
    mode_t            target_reg;
    logic             req_valid;

    cdc_sync_bit #(.RST_VAL(1'b0)) u_lock_sync (
        .clk       (SYS_CLK),
        .rst_n     (RESET_N),
        .async_bit (pll_locked_i),
        .sync_bit  (lock_sync)
    );

    cdc_sync_bit #(.RST_VAL(1'b0)) u_frame_sync (
        .clk       (SYS_CLK),
        .rst_n     (RESET_N),
        .async_bit (frame_tgl_i),
        .sync_bit  (frame_sync)
    );

    // Each toggle of the pixel-domain flag becomes a one-cycle registered event.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_dly_reg <= 1'b0;
            frame_evt_reg <= 1'b0;
        end else begin
            frame_dly_reg <= frame_sync;
            frame_evt_reg <= frame_sync ^ frame_dly_reg;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cand_reg    <= 2'(DEFAULT_MODE);
            deb_cnt_reg <= '0;
        end else if (mode_req_i != cand_reg) begin
            cand_reg    <= mode_req_i;
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg != DEB_LAST) begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
    end

    assign req_valid = (deb_cnt_reg == DEB_LAST) && (int'(cand_reg) < NUM_MODES)
                       && (cand_reg != active_mode_o);

    // Every transition clears cnt_reg; outputs are updated alongside the state they belong to.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_WAIT_LOCK;
            target_reg     <= DEF_MODE;
            cnt_reg        <= '0;
            active_mode_o  <= DEF_MODE;
            pll_cfg_mode_o <= DEF_MODE;
            pll_cfg_req_o  <= 1'b0;
            tg_rst_o       <= 1'b1;
            tg_blank_o     <= 1'b1;
            busy_o         <= 1'b1;
            err_o          <= 1'b0;
        end else begin
            if (cnt_reg != CNT_SAT) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!lock_sync) begin
                        state_reg  <= ST_WAIT_LOCK;
                        cnt_reg    <= '0;
                        target_reg <= mode_t'(active_mode_o);
                        tg_rst_o   <= 1'b1;
                        tg_blank_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end else if (req_valid) begin
                        state_reg  <= ST_ARMED;
                        cnt_reg    <= '0;
                        target_reg <= mode_t'(cand_reg);
                        tg_blank_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (frame_evt_reg || cnt_reg == FRAME_LAST) begin
                        state_reg      <= ST_RECONF;
                        cnt_reg        <= '0;
                        pll_cfg_req_o  <= 1'b1;
                        pll_cfg_mode_o <= target_reg;
                        tg_rst_o       <= 1'b1;
                    end
                end
                ST_RECONF: begin
                    if (pll_cfg_done_i) begin
                        state_reg     <= ST_WAIT_LOCK;
                        cnt_reg       <= '0;
                        pll_cfg_req_o <= 1'b0;
                        active_mode_o <= target_reg;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_reg <= ST_SETTLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        err_o   <= 1'b1;
                        cnt_reg <= '0;
                        if (target_reg != DEF_MODE) begin
                            state_reg      <= ST_RECONF;
                            target_reg     <= DEF_MODE;
                            pll_cfg_req_o  <= 1'b1;
                            pll_cfg_mode_o <= DEF_MODE;
                        end else begin
                            state_reg <= ST_FAULT;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!lock_sync) begin
                        state_reg <= ST_WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == SETTLE_LAST) begin
                        state_reg <= ST_UNBLANK;
                        cnt_reg   <= '0;
                        tg_rst_o  <= 1'b0;
                    end
                end
                ST_UNBLANK: begin
                    if (frame_evt_reg) begin
                        state_reg  <= ST_IDLE;
                        cnt_reg    <= '0;
                        tg_blank_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else if (cnt_reg == FRAME_LAST) begin
                        state_reg <= ST_FAULT;
                        cnt_reg   <= '0;
                        tg_rst_o  <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    pll_cfg_req_o <= 1'b0;
                    tg_rst_o      <= 1'b1;
                    tg_blank_o    <= 1'b1;
                    busy_o        <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_FAULT;
                    cnt_reg       <= '0;
                    pll_cfg_req_o <= 1'b0;
                    tg_rst_o      <= 1'b1;
                    tg_blank_o    <= 1'b1;
                    busy_o        <= 1'b1;
                end
            endcase
        end
    end

endmodule
